// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and bit-counter width helper for serial_subtractor
package serial_subtractor_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done bus; master drives start,a,b; slave drives busy,done,diff,bout,ovf
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  modport master(output start, a, b, input busy, done, diff, bout, ovf);
  modport slave(input start, a, b, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor_fullsub_s.sv
// fullsub_s: gate-level 1-bit full subtractor; in a,b,bin; out dout=a^b^bin, bout=borrow
module fullsub_s (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic dout,
  output logic bout
);
  logic t, na, nt, p, q;
  xor x1 (t, a, b);
  xor x2 (dout, t, bin);
  not n1 (na, a);
  and g1 (p, na, b);
  not n2 (nt, t);
  and g2 (q, nt, bin);
  or  o1 (bout, p, q);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b LSB first; ports clk, rst (sync high), s (slave: start,a,b -> busy,done,diff,bout,ovf)
module serial_subtractor import serial_subtractor_pkg::*; #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave s
);
  localparam int CW = cnt_w(WIDTH);
  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, diff_r;
  logic [CW-1:0]    count;
  logic             borrow, bout_r, ovf_r, a_msb, b_msb, d, bn, last;
  fullsub_s u_fs (.a(sa[0]), .b(sb[0]), .bin(borrow), .dout(d), .bout(bn));
  assign last = count == CW'(WIDTH - 1);
  always_comb begin
    state_n = state == ST_IDLE ? (s.start ? ST_RUN : ST_IDLE) :
              state == ST_RUN  ? (last ? ST_DONE : ST_RUN) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      diff_r <= '0;
      count  <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && s.start) begin
        sa     <= s.a;
        sb     <= s.b;
        borrow <= 1'b0;
        count  <= '0;
        a_msb  <= s.a[WIDTH-1];
        b_msb  <= s.b[WIDTH-1];
      end else if (state == ST_RUN) begin
        diff_r <= {d, diff_r[WIDTH-1:1]};
        sa     <= sa >> 1;
        sb     <= sb >> 1;
        borrow <= bn;
        count  <= last ? '0 : count + CW'(1);
        if (last) begin
          bout_r <= bn;
          ovf_r  <= (a_msb ^ b_msb) & (d ^ a_msb);
        end
      end
    end
  end
  assign s.busy = state == ST_RUN;
  assign s.done = state == ST_DONE;
  assign s.diff = diff_r;
  assign s.bout = bout_r;
  assign s.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_subtractor_if #(.WIDTH(8)) s ();
  serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .s(s));
  typedef struct packed {logic [7:0] d; logic bo; logic ov;} exp_t;
  exp_t q[$];
  int checks = 0;
  int fails = 0;
  logic prev_done = 1'b0;
  logic [7:0] last_diff = '0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", n, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (rst) prev_done = 1'b0;
    else begin
      if (prev_done) begin
        chk("done_no_repeat", 32'(s.done), 0);
        chk("hold_diff", 32'(s.diff), 32'(last_diff));
      end
      if (s.done) begin
        chk("sb_pending", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("diff", 32'(s.diff), 32'(e.d));
          chk("bout", 32'(s.bout), 32'(e.bo));
          chk("ovf", 32'(s.ovf), 32'(e.ov));
        end
      end
      prev_done = s.done;
      last_diff = s.diff;
    end
  end
  task automatic run(input logic [7:0] ia, ib, ed, input logic eb, eo, input bit poke);
    int k, busy_n;
    busy_n = 0;
    s.a = ia;
    s.b = ib;
    s.start = 1'b1;
    q.push_back('{ed, eb, eo});
    @(negedge clk);
    s.start = 1'b0;
    s.a = ~ia;
    s.b = ~ib;
    k = 1;
    while (!s.done && k < 20) begin
      if (poke && k == 3) begin
        s.start = 1'b1;
        s.a = 8'hFF;
        s.b = 8'h00;
      end
      if (poke && k == 4) begin
        s.start = 1'b0;
        s.a = 8'h55;
        s.b = 8'hAA;
      end
      busy_n += 32'(s.busy);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 9);
    chk("busy_cycles", 32'(busy_n), 8);
    @(negedge clk);
  endtask
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!s.done && k < 30);
  endtask
  initial begin
    int k;
    s.start = 1'b0;
    s.a = '0;
    s.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(s.busy), 0);
    chk("rst_done", 32'(s.done), 0);
    chk("rst_diff", 32'(s.diff), 0);
    chk("rst_bout", 32'(s.bout), 0);
    chk("rst_ovf", 32'(s.ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    run(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    s.a = 8'h05;
    s.b = 8'h03;
    s.start = 1'b1;
    @(negedge clk);
    s.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(s.busy), 0);
    chk("abort_done", 32'(s.done), 0);
    chk("abort_diff", 32'(s.diff), 0);
    chk("abort_bout", 32'(s.bout), 0);
    chk("abort_ovf", 32'(s.ovf), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run(8'hC8, 8'h32, 8'h96, 1'b0, 1'b0, 1'b0);
    repeat (3) q.push_back('{8'h0F, 1'b0, 1'b0});
    s.a = 8'h10;
    s.b = 8'h01;
    s.start = 1'b1;
    wait_done(k);
    chk("b2b_first", 32'(k), 9);
    repeat (2) begin
      wait_done(k);
      chk("b2b_interval", 32'(k), 10);
    end
    s.start = 1'b0;
    repeat (14) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
